// File: rtl/accel_pkg.sv
// Shared definitions for the accelerometer tick sampler: interval-timer register map,
// control bit positions, sampler FSM states and the 48-bit timestamp record.
package accel_pkg;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;
  localparam logic [2:0] TMR_SNAPL   = 3'd4;
  localparam logic [2:0] TMR_SNAPH   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    ST_CFG_PL,
    ST_CFG_PH,
    ST_CFG_CTRL,
    ST_IDLE,
    ST_CLR,
    ST_SNAP,
    ST_RD_L,
    ST_RD_H,
    ST_CAP,
    ST_PUSH
  } tick_state_e;

  typedef struct packed {
    logic [15:0] seq;
    logic [31:0] snap;
  } tick_rec_t;

  // Control word that starts the timer with the timeout interrupt enabled.
  function automatic logic [15:0] ctrl_word(input logic cont);
    logic [15:0] w;
    w             = '0;
    w[CTRL_ITO]   = 1'b1;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = 1'b1;
    w[CTRL_STOP]  = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/accel_tick_fifo.sv
// Synchronous first-word-fall-through FIFO: the head entry is driven straight from
// registered storage. A push into a full FIFO succeeds only when a pop happens in the same cycle.
module accel_tick_fifo
  import accel_pkg::*;
#(
  parameter int WIDTH = $bits(tick_rec_t),
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = rd_en && !empty;
  assign push    = wr_en && (!full || pop);
  assign rd_data = mem_q[rd_ptr_q];

  // Pointers are AW bits wide, so the increments wrap modulo DEPTH on their own.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/accel_tick_sampler.sv
// Avalon-MM master that programs the interval timer, then timestamps every timeout into a FIFO.
// Build option TICK_OVERRUN_CNT_EN adds the overrun pulse and saturating drop counter.
module accel_tick_sampler
  import accel_pkg::*;
#(
  parameter int PERIOD     = 50000,
  parameter int FIFO_DEPTH = 4,
  parameter int CONTINUOUS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_data,
  output logic        cfg_done
`ifdef TICK_OVERRUN_CNT_EN
 ,output logic        overrun,
  output logic [15:0] overrun_cnt
`endif
);

  localparam logic [31:0] LOAD_VAL = 32'(PERIOD - 1);
  localparam logic [15:0] CTRL_VAL = ctrl_word(CONTINUOUS != 0);

  tick_state_e state_q, state_d;
  logic        started_q, started_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wd_q, wd_d;
  logic        cfg_done_q, cfg_done_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [15:0] snap_hi_q, snap_hi_d;

  logic        push_req, drop, fifo_empty, fifo_full;
  tick_rec_t   push_rec;

  assign push_req      = (state_q == ST_PUSH);
  assign drop          = push_req && fifo_full && !out_ready;
  assign push_rec.seq  = seq_q;
  assign push_rec.snap = {snap_hi_q, snap_lo_q};

  // Bus outputs are registered from the next state so each access lines up with its state.
  // The first cycle after reset only primes that register, holding the FSM in CFG_PL.
  always_comb begin
    state_d   = state_q;
    started_d = 1'b1;
    seq_d     = seq_q;
    snap_lo_d = snap_lo_q;
    snap_hi_d = snap_hi_q;
    if (started_q) begin
      case (state_q)
        ST_CFG_PL:   state_d = ST_CFG_PH;
        ST_CFG_PH:   state_d = ST_CFG_CTRL;
        ST_CFG_CTRL: state_d = ST_IDLE;
        ST_IDLE:     if (tmr_irq) state_d = ST_CLR;
        ST_CLR:      state_d = ST_SNAP;
        ST_SNAP:     state_d = ST_RD_L;
        ST_RD_L:     state_d = ST_RD_H;
        ST_RD_H: begin
          snap_lo_d = tmr_readdata;
          state_d   = ST_CAP;
        end
        ST_CAP: begin
          snap_hi_d = tmr_readdata;
          state_d   = ST_PUSH;
        end
        ST_PUSH: begin
          seq_d   = seq_q + 16'd1;
          state_d = ST_IDLE;
        end
        default:     state_d = ST_CFG_PL;
      endcase
    end

    cfg_done_d = cfg_done_q || (state_d == ST_IDLE);

    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 3'd0;
    wd_d   = 16'd0;
    case (state_d)
      ST_CFG_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_PERIODL; wd_d = LOAD_VAL[15:0];  end
      ST_CFG_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_PERIODH; wd_d = LOAD_VAL[31:16]; end
      ST_CFG_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_CONTROL; wd_d = CTRL_VAL;        end
      ST_CLR:      begin cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_STATUS;                          end
      ST_SNAP:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = TMR_SNAPL;                           end
      ST_RD_L:     begin cs_d = 1'b1;              addr_d = TMR_SNAPL;                           end
      ST_RD_H:     begin cs_d = 1'b1;              addr_d = TMR_SNAPH;                           end
      default:     begin end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CFG_PL;
      started_q  <= 1'b0;
      cs_q       <= 1'b0;
      wn_q       <= 1'b1;
      addr_q     <= 3'd0;
      wd_q       <= 16'd0;
      cfg_done_q <= 1'b0;
      seq_q      <= 16'd0;
      snap_lo_q  <= 16'd0;
      snap_hi_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      started_q  <= started_d;
      cs_q       <= cs_d;
      wn_q       <= wn_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      cfg_done_q <= cfg_done_d;
      seq_q      <= seq_d;
      snap_lo_q  <= snap_lo_d;
      snap_hi_q  <= snap_hi_d;
    end
  end

  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_address    = addr_q;
  assign tmr_writedata  = wd_q;
  assign cfg_done       = cfg_done_q;
  assign out_valid      = !fifo_empty;

  accel_tick_fifo #(
    .WIDTH ($bits(tick_rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push_req && !drop),
    .wr_data (push_rec),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

`ifdef TICK_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (drop && (ovr_cnt_q != 16'hFFFF)) begin
      ovr_cnt_d = ovr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_cnt_q <= 16'd0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign overrun     = drop;
  assign overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_accel_tick_sampler.sv
// Bench for accel_tick_sampler: a small interval-timer model, randomized ticks and a
// queue scoreboard of expected {seq, snapshot} records.
module tb_accel_tick_sampler;

  localparam int PERIOD = 50000;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata = 16'h0;
  logic        tmr_irq = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] out_data;
  logic        cfg_done;
`ifdef TICK_OVERRUN_CNT_EN
  logic        overrun;
  logic [15:0] overrun_cnt;
`endif

  accel_tick_sampler #(
    .PERIOD     (PERIOD),
    .FIFO_DEPTH (DEPTH),
    .CONTINUOUS (1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .tmr_irq        (tmr_irq),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .cfg_done       (cfg_done)
`ifdef TICK_OVERRUN_CNT_EN
   ,.overrun        (overrun),
    .overrun_cnt    (overrun_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [47:0] exp_q[$];
  logic [15:0] model_seq = 16'd0;
  int          model_drops = 0;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- timer slave model ----------------
  int          fire_cnt = 0;
  int          fire_seen = 0;
  int          clear_delay = 0;
  int          clr_cd = 0;
  logic [31:0] snap_val = 32'h0;
  logic [31:0] snap_lat = 32'h0;

  always @(posedge clk) begin
    if (!reset_n) begin
      tmr_irq      <= 1'b0;
      tmr_readdata <= 16'h0;
      clr_cd       <= 0;
      fire_seen    <= fire_cnt;
    end else begin
      tmr_readdata <= 16'h0;
      if (tmr_chipselect && tmr_write_n) begin
        if (tmr_address == 3'd4) tmr_readdata <= snap_lat[15:0];
        if (tmr_address == 3'd5) tmr_readdata <= snap_lat[31:16];
      end
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd4) snap_lat <= snap_val;
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) begin
        if (clear_delay == 0) tmr_irq <= 1'b0;
        else clr_cd <= clear_delay;
      end else if (clr_cd != 0) begin
        clr_cd <= clr_cd - 1;
        if (clr_cd == 1) tmr_irq <= 1'b0;
      end
      if (fire_cnt != fire_seen) begin
        tmr_irq   <= 1'b1;
        fire_seen <= fire_cnt;
      end
    end
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  typedef struct {
    int          cyc;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  bus_t bus_log[$];
  int   n_irq = 0, irq_cyc = 0;
  int   n_vrise = 0, valid_rise = 0;
  int   cfg_cyc = 0;
  int   n_acc = 0;
  int   n_ovr = 0;
  logic irq_prev = 1'b0, valid_prev = 1'b0, cfg_prev = 1'b0;

  always @(negedge clk) begin
    if (tmr_chipselect) bus_log.push_back('{cyc, !tmr_write_n, tmr_address, tmr_writedata});
    if (tmr_irq && !irq_prev) begin
      n_irq++;
      irq_cyc = cyc;
    end
    if (out_valid && !valid_prev) begin
      n_vrise++;
      valid_rise = cyc;
    end
    if (cfg_done && !cfg_prev) cfg_cyc = cyc;
    irq_prev   = tmr_irq;
    valid_prev = out_valid;
    cfg_prev   = cfg_done;
    if (out_valid && out_ready) begin
      n_acc++;
      if (exp_q.size() == 0) check_eq("rec_expected", 48'(exp_q.size()), 48'd1);
      else check_eq("rec", out_data, exp_q.pop_front());
    end
`ifdef TICK_OVERRUN_CNT_EN
    if (overrun) n_ovr++;
`endif
  end

  // ---------------- expected bus sequences ----------------
  function automatic logic [19:0] cfg_txn(input int k);
    logic [31:0] load;
    load = 32'(PERIOD - 1);
    case (k)
      0:       return {1'b1, 3'd2, load[15:0]};
      1:       return {1'b1, 3'd3, load[31:16]};
      default: return {1'b1, 3'd1, 16'h0007};
    endcase
  endfunction

  // {cycles after irq, write, address, write data}
  function automatic logic [27:0] svc_txn(input int k);
    case (k)
      0:       return {8'd1, 1'b1, 3'd0, 16'h0};
      1:       return {8'd2, 1'b1, 3'd4, 16'h0};
      2:       return {8'd3, 1'b0, 3'd4, 16'h0};
      default: return {8'd4, 1'b0, 3'd5, 16'h0};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_bus"}, 48'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, out_valid, cfg_done}),
             48'({1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0}));
    check_eq({tag, "_data"}, out_data, 48'h0);
`ifdef TICK_OVERRUN_CNT_EN
    check_eq({tag, "_ovr"}, 48'({overrun, overrun_cnt}), 48'h0);
`endif
  endtask

  task automatic check_config(input int b0);
    int n;
    n = bus_log.size() - b0;
    check_eq("cfg_cnt", 48'(n), 48'd3);
    if (n == 3) begin
      for (int k = 0; k < 3; k++) begin
        check_eq("cfg_txn", 48'({bus_log[b0+k].wr, bus_log[b0+k].addr, bus_log[b0+k].data}), 48'(cfg_txn(k)));
      end
      check_eq("cfg_consec", 48'(bus_log[b0+2].cyc - bus_log[b0].cyc), 48'd2);
      check_eq("cfg_done_cyc", 48'(cfg_cyc - bus_log[b0+2].cyc), 48'd1);
    end
    check_eq("cfg_done", 48'(cfg_done), 48'd1);
  endtask

  task automatic wait_irq(input int i0);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step(1);
      seen = (n_irq > i0);
    end
    check_eq("irq_seen", 48'(seen), 48'd1);
  endtask

  // One timeout. pulse_ready raises out_ready only for the PUSH cycle.
  task automatic tick(input logic [31:0] snap, input int cdelay, input bit pulse_ready);
    int i0, b0, v0, n;
    logic [27:0] got;
    i0 = n_irq;
    b0 = bus_log.size();
    v0 = n_vrise;
    snap_val    = snap;
    clear_delay = cdelay;
    if (pulse_ready || exp_q.size() < DEPTH) exp_q.push_back({model_seq, snap});
    else model_drops++;
    model_seq++;
    fire_cnt++;
    wait_irq(i0);
    if (pulse_ready) begin
      while (cyc < irq_cyc + 6) step(1);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
    end
    step(12);
    n = bus_log.size() - b0;
    check_eq("svc_cnt", 48'(n), 48'd4);
    if (n == 4) begin
      for (int k = 0; k < 4; k++) begin
        got = {8'(bus_log[b0+k].cyc - irq_cyc), bus_log[b0+k].wr, bus_log[b0+k].addr,
               bus_log[b0+k].wr ? bus_log[b0+k].data : 16'h0};
        check_eq("svc_txn", 48'(got), 48'(svc_txn(k)));
      end
    end
    if (out_ready) begin
      check_eq("vrise", 48'(n_vrise - v0), 48'd1);
      check_eq("latency", 48'(valid_rise - irq_cyc), 48'd7);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) step(1);
    check_eq("drain", 48'(exp_q.size()), 48'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b0, a0, i0;

    // Reset and configuration
    step(3);
    check_idle_outputs("reset");
    b0 = bus_log.size();
    reset_n = 1'b1;
    step(10);
    check_config(b0);

    // Directed tick: snapshot 0x0001_2345 becomes record 0x0000_0001_2345
    tick(32'h0001_2345, 0, 1'b0);
    drain();

    // irq held high past the status clear must not be serviced twice
    tick(32'hDEAD_BEEF, 3, 1'b0);
    tick(32'h0000_FFFF, 2, 1'b0);
    drain();

    // Randomized ticks, consumer always ready
    for (int t = 0; t < 6; t++) begin
      step($urandom_range(0, 8));
      tick($urandom, $urandom_range(0, 3), 1'b0);
    end
    drain();

    // Consumer stalled: DEPTH records held, the next one dropped
    out_ready = 1'b0;
    for (int t = 0; t < DEPTH + 1; t++) begin
      tick($urandom, 0, 1'b0);
      check_eq("stall_valid", 48'(out_valid), 48'd1);
      check_eq("stall_head", out_data, exp_q[0]);
    end
`ifdef TICK_OVERRUN_CNT_EN
    check_eq("overrun_cnt", 48'(overrun_cnt), 48'(model_drops));
    check_eq("overrun_pulses", 48'(n_ovr), 48'(model_drops));
`endif
    a0 = n_acc;
    out_ready = 1'b1;
    drain();
    check_eq("stall_drained", 48'(n_acc - a0), 48'(DEPTH));
    tick($urandom, 0, 1'b0);
    drain();

    // Full FIFO with a pop in the PUSH cycle: the new record is kept
    out_ready = 1'b0;
    for (int t = 0; t < DEPTH; t++) tick($urandom, 0, 1'b0);
    a0 = n_acc;
    tick($urandom, 0, 1'b1);
    check_eq("full_pop_model", 48'(exp_q.size()), 48'(DEPTH));
    check_eq("full_pop_head", out_data, exp_q[0]);
`ifdef TICK_OVERRUN_CNT_EN
    check_eq("full_pop_ovr", 48'(overrun_cnt), 48'(model_drops));
`endif
    out_ready = 1'b1;
    drain();
    check_eq("full_pop_total", 48'(n_acc - a0), 48'(DEPTH + 1));

    // Reset asserted while the FSM is in RD_H
    i0 = n_irq;
    snap_val = $urandom;
    clear_delay = 0;
    fire_cnt++;
    wait_irq(i0);
    while (cyc < irq_cyc + 4) step(1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_q.delete();
    model_seq = 16'd0;
    model_drops = 0;
    step(3);
    b0 = bus_log.size();
    reset_n = 1'b1;
    step(10);
    check_config(b0);
    tick($urandom, 0, 1'b0);
    drain();
    check_eq("cfg_done_hold", 48'(cfg_done), 48'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
